masked_compare_pipe: RTL and testbench

// - Streaming multi-channel comparator. Each input beat is compared against CHANNELS programmable reference

---
 rtl/masked_compare_pipe_if.sv | 40 ++++
 rtl/masked_compare_pipe.sv | 181 ++++++++++++++++++
 tb/tb_masked_compare_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/masked_compare_pipe_if.sv
// Stream interface for masked_compare_pipe.
// Groups the input beat handshake (in_valid/in_ready/in_data) and the result handshake
// (out_valid/out_ready/out_match/out_any/out_data).
//   master : data source and result sink (drives in_valid, in_data, out_ready)
//   slave  : the comparator stage (drives in_ready and all out_* result signals)
interface masked_compare_pipe_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [CHANNELS-1:0] out_match;
    logic                out_any;
    logic [WIDTH-1:0]    out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_match,
        input  out_any,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_match,
        output out_any,
        output out_data
    );
endinterface

// File: rtl/masked_compare_pipe.sv
// masked_compare_pipe: streaming multi-channel comparator, one registered pipeline stage.
// Each accepted beat is compared against CHANNELS programmable patterns, each with its own
// mode (00 EQ, 01 NEQ, 10 WEQ, 11 WNEQ) and don't-care mask (wildcard modes only).
// Any X/Z on a compared input bit forces that channel's result to 0.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cfg_we/cfg_ch   config write strobe and target channel (out-of-range writes ignored)
//   cfg_mode/cfg_pattern/cfg_mask  config values committed at the clock edge
//   bus             stream interface (slave): in_valid/in_ready/in_data in,
//                   out_valid/out_ready/out_match/out_any/out_data out
//   cnt_clr         clear all hit counters
//   hit_cnt         per-channel saturating hit counters, ch0 in the LSBs
//
// Optional feature: define MATCH_CNT_EN to build the per-channel hit counters. Without it,
// hit_cnt is tied to 0 and cnt_clr is ignored.
module masked_compare_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [WIDTH-1:0]          cfg_pattern,
    input  logic [WIDTH-1:0]          cfg_mask,
    input  logic                      cnt_clr,
    output logic [CHANNELS*CNT_W-1:0] hit_cnt,
    masked_compare_pipe_if.slave      bus
);

    // ------------------------------------------------------------------
    // Per-channel configuration
    // ------------------------------------------------------------------
    logic [1:0]       mode_q    [CHANNELS];
    logic [1:0]       mode_d    [CHANNELS];
    logic [WIDTH-1:0] pattern_q [CHANNELS];
    logic [WIDTH-1:0] pattern_d [CHANNELS];
    logic [WIDTH-1:0] mask_q    [CHANNELS];
    logic [WIDTH-1:0] mask_d    [CHANNELS];

    // Only indices that exist are matched, so an out-of-range cfg_ch selects nothing.
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            mode_d[c]    = mode_q[c];
            pattern_d[c] = pattern_q[c];
            mask_d[c]    = mask_q[c];
            if (cfg_we && (cfg_ch == CH_W'(c))) begin
                mode_d[c]    = cfg_mode;
                pattern_d[c] = cfg_pattern;
                mask_d[c]    = cfg_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (rst) begin
                mode_q[c]    <= 2'b00;
                pattern_q[c] <= '0;
                mask_q[c]    <= '0;
            end else begin
                mode_q[c]    <= mode_d[c];
                pattern_q[c] <= pattern_d[c];
                mask_q[c]    <= mask_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare (uses the registered config, so a same-cycle write is not yet visible)
    // ------------------------------------------------------------------
    // mode[1] selects the wildcard (masked) forms, mode[0] inverts the result.
    logic [CHANNELS-1:0] cmp;

    always_comb begin
        logic [WIDTH-1:0] care;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] xbits;
        logic             known;
        logic             same;
        cmp = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            care  = mode_q[c][1] ? ~mask_q[c] : {WIDTH{1'b1}};
            diff  = (bus.in_data ^ pattern_q[c]) & care;
            // a ^ a is 0 for a known bit and X for an X/Z bit; masked bits drop out.
            xbits = (bus.in_data ^ bus.in_data) & care;
            known = (xbits === {WIDTH{1'b0}});
            same  = (diff == {WIDTH{1'b0}});
            cmp[c] = known ? (same ^ mode_q[c][0]) : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic                out_valid_q, out_valid_d;
    logic [CHANNELS-1:0] out_match_q, out_match_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic                accept;
    logic                handshake;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign handshake    = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_match_d = out_match_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_match_d = cmp;
            out_data_d  = bus.in_data;
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_match_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_match_q <= out_match_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_match = out_match_q;
    assign bus.out_any   = |out_match_q;
    assign bus.out_data  = out_data_q;

    // ------------------------------------------------------------------
    // Hit counters
    // ------------------------------------------------------------------
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            cnt_d[c] = cnt_q[c];
            if (cnt_clr) begin
                cnt_d[c] = '0;
            end else if (handshake && out_match_q[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (rst) begin
                cnt_q[c] <= '0;
            end else begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_masked_compare_pipe.sv
// Directed self-checking bench for masked_compare_pipe (WIDTH=8, CHANNELS=4).
// Build with MATCH_CNT_EN defined to exercise the counters at CNT_W=2.
module tb_masked_compare_pipe;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;
`ifdef MATCH_CNT_EN
    localparam int unsigned CNT_W    = 2;
`else
    localparam int unsigned CNT_W    = 16;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cfg_we;
    logic [1:0]                cfg_ch;
    logic [1:0]                cfg_mode;
    logic [WIDTH-1:0]          cfg_pattern;
    logic [WIDTH-1:0]          cfg_mask;
    logic                      cnt_clr;
    logic [CHANNELS*CNT_W-1:0] hit_cnt;

    int total = 0;
    int bad   = 0;
    logic probe;
    bit   four_state;

    masked_compare_pipe_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    masked_compare_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cnt_clr     (cnt_clr),
        .hit_cnt     (hit_cnt),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; drive and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [7:0] pat, input logic [7:0] msk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_pattern = pat; cfg_mask = msk;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_match !== 4'b0000) begin bad++;
            $display("FAIL reset_out_match got=%b want=0000", bus.out_match); end
        total++; if (bus.out_any !== 1'b0) begin bad++;
            $display("FAIL reset_out_any got=%b want=0", bus.out_any); end
        total++; if (bus.out_data !== 8'h00) begin bad++;
            $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
        total++; if (bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (hit_cnt !== '0) begin bad++;
            $display("FAIL reset_hit_cnt got=%h want=0", hit_cnt); end
    endtask

    task automatic test_default_eq();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL default_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.out_match !== 4'b1111) begin bad++;
            $display("FAIL default_match got=%b want=1111", bus.out_match); end
        total++; if (bus.out_any !== 1'b1) begin bad++;
            $display("FAIL default_any got=%b want=1", bus.out_any); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL default_valid_clear got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_modes();
        cfg_write(2'd1, 2'b10, 8'hA0, 8'h0F);
        cfg_write(2'd2, 2'b01, 8'hA5, 8'h00);
        cfg_write(2'd3, 2'b10, 8'h55, 8'hFF);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        step();
        // ch0 EQ 00 no, ch1 WEQ A0/0F yes, ch2 NEQ A5 no, ch3 all don't-care yes
        total++; if (bus.out_match !== 4'b1010) begin bad++;
            $display("FAIL modes_a5 got=%b want=1010", bus.out_match); end
        bus.in_data = 8'hB5;
        step();
        total++; if (bus.out_match !== 4'b1100 || bus.out_data !== 8'hB5) begin bad++;
            $display("FAIL modes_b5 got=%b/%h want=1100/b5", bus.out_match, bus.out_data); end
        cfg_write(2'd3, 2'b11, 8'h55, 8'hFF);
        bus.in_data = 8'h00;
        step();
        // ch0 EQ 00 yes, ch1 A0 high nibble differs, ch2 NEQ yes, ch3 WNEQ all-mask no
        total++; if (bus.out_match !== 4'b0101) begin bad++;
            $display("FAIL modes_wneq_ones got=%b want=0101", bus.out_match); end
        drain();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h21;
        step();
        bus.in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h21
                         || bus.out_valid !== 1'b1) begin bad++;
                $display("FAIL bp_hold%0d got rdy=%b data=%h want rdy=0 data=21",
                         i, bus.in_ready, bus.out_data); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
        step();
        total++; if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL bp_next got=%h want=22", bus.out_data); end
        bus.in_data = 8'h23;
        step();
        total++; if (bus.out_data !== 8'h23) begin bad++;
            $display("FAIL bp_last got=%h want=23", bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL bp_drained got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_cfg_same_cycle();
        bus.out_ready = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b00; cfg_pattern = 8'h11; cfg_mask = 8'h00;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        step();
        cfg_we = 1'b0;
        total++; if (bus.out_match[0] !== 1'b0) begin bad++;
            $display("FAIL cfg_old_used got=%b want=0", bus.out_match[0]); end
        step();
        total++; if (bus.out_match[0] !== 1'b1) begin bad++;
            $display("FAIL cfg_new_used got=%b want=1", bus.out_match[0]); end
        // rewrite while the result is stalled: registered result must not move
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        cfg_write(2'd0, 2'b00, 8'h22, 8'h00);
        total++; if (bus.out_match[0] !== 1'b1 || bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL cfg_no_retro got=%b want=1", bus.out_match[0]); end
        drain();
    endtask

    task automatic test_xcheck();
        cfg_write(2'd0, 2'b00, 8'hA0, 8'h00);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'b1010_xxxx;
        step();
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        total++; if (bus.out_match[1] !== 1'b1) begin bad++;
            $display("FAIL x_masked got=%b want=1", bus.out_match[1]); end
        // X can only be observed on a four-state simulator
        if (four_state) begin
            total++; if (bus.out_match[0] !== 1'b0) begin bad++;
                $display("FAIL x_eq got=%b want=0", bus.out_match[0]); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        step();
        bus.in_valid = 1'b0;
        do_reset();
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin bad++;
            $display("FAIL rst_mid got v=%b d=%h want v=0 d=00", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_match !== 4'b1111) begin bad++;
            $display("FAIL rst_mid_cfg got=%b want=1111", bus.out_match); end
        drain();
    endtask

`ifdef MATCH_CNT_EN
    task automatic test_counter();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            // after step i, i handshakes have completed
            if (i == 2) begin
                total++; if (hit_cnt !== 8'hAA) begin bad++;
                    $display("FAIL cnt_two got=%h want=aa", hit_cnt); end
            end
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (hit_cnt !== 8'hFF) begin bad++;
            $display("FAIL cnt_saturate got=%h want=ff", hit_cnt); end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (hit_cnt !== 8'h00) begin bad++;
            $display("FAIL cnt_clr_prio got=%h want=00", hit_cnt); end
    endtask
`else
    task automatic test_no_counter();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        step();
        step();
        bus.in_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (hit_cnt !== '0) begin bad++;
            $display("FAIL no_cnt got=%h want=0", hit_cnt); end
    endtask
`endif

    initial begin
        probe = 1'bx;
        four_state = (probe === 1'bx);
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_pattern = '0;
        cfg_mask = '0; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        test_reset();
        test_default_eq();
        test_modes();
        test_backpressure();
        test_cfg_same_cycle();
        test_xcheck();
        test_reset_mid();
`ifdef MATCH_CNT_EN
        test_counter();
`else
        test_no_counter();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
